// File: rtl/jmp_pkg.sv
// Shared jump-uop definitions for rename, the dispatch buffer and the jump IQ.
package jmp_pkg;

  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int XLEN   = 32;
  localparam int POS_W  = 6;

  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic              prs1_valid;
    logic [PREG_W-1:0] prs2;
    logic              prs2_valid;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [AREG_W-1:0] rd;
    logic [XLEN-1:0]   pc;
  } jmp_uop_t;

  localparam int JMP_UOP_W = $bits(jmp_uop_t);

  // Free IQ slots visible this cycle; no_free wins if both flags are raised.
  function automatic logic [1:0] iq_free_f(input logic no_free, input logic one_free);
    if (no_free) return 2'd0;
    else if (one_free) return 2'd1;
    else return 2'd2;
  endfunction

endpackage

// File: rtl/jmp_dispatch_ctrl.sv
// Pointer/occupancy bookkeeping for jmp_dispatch_buf; decides push, pop and bypass counts.
// Optional same-cycle bypass enabled by defining JMP_DISP_BYPASS_EN.
module jmp_dispatch_ctrl
  import jmp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid1,
  input  logic                      in_valid2,
  input  logic                      no_free_iq_jmp,
  input  logic                      one_free_iq_jmp,
  output logic                      in_ready,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [$clog2(DEPTH)-1:0]  rd_idx,
  output logic [$clog2(DEPTH)-1:0]  wr_idx,
  output logic [1:0]                disp_n,
  output logic [1:0]                buf_pop_n,
  output logic [1:0]                in_take_n,
  output logic [1:0]                wr_n
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] RDY_MAX = PW'(DEPTH - 2);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_occ;

  logic       w_in_ready;
  logic [1:0] w_push_n;
  logic [1:0] w_iq_free;
  logic [1:0] w_buf_avail;
  logic [1:0] w_avail;
  logic [2:0] w_avail_sum;
  logic [1:0] w_disp_n;
  logic [1:0] w_buf_pop;
  logic [1:0] w_in_take;
  logic [1:0] w_wr_n;

  // in_ready depends on registered occupancy only, so rename never sees IQ flags.
  assign w_in_ready = (r_occ <= RDY_MAX);
  assign w_iq_free  = iq_free_f(no_free_iq_jmp, one_free_iq_jmp);

  always_comb begin
    w_push_n    = 2'd0;
    w_avail_sum = 3'd0;
    w_avail     = 2'd0;
    w_disp_n    = 2'd0;
    w_buf_pop   = 2'd0;
    w_in_take   = 2'd0;
    if (!flush && w_in_ready)
      w_push_n = {1'b0, in_valid1} + {1'b0, in_valid2};
    w_buf_avail = (r_occ >= PW'(2)) ? 2'd2 : r_occ[1:0];
`ifdef JMP_DISP_BYPASS_EN
    // Buffered entries are older than incoming uops, so they fill the slots first.
    w_avail_sum = {1'b0, w_buf_avail} + {1'b0, w_push_n};
    w_avail     = (w_avail_sum >= 3'd2) ? 2'd2 : w_avail_sum[1:0];
`else
    w_avail     = w_buf_avail;
`endif
    if (!flush)
      w_disp_n = (w_avail < w_iq_free) ? w_avail : w_iq_free;
`ifdef JMP_DISP_BYPASS_EN
    w_buf_pop = (w_disp_n < w_buf_avail) ? w_disp_n : w_buf_avail;
    w_in_take = w_disp_n - w_buf_pop;
`else
    w_buf_pop = w_disp_n;
    w_in_take = 2'd0;
`endif
    w_wr_n = w_push_n - w_in_take;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_buf_pop);
      r_wr_ptr <= r_wr_ptr + PW'(w_wr_n);
      r_occ    <= r_occ + PW'(w_wr_n) - PW'(w_buf_pop);
    end
  end

  assign in_ready  = w_in_ready;
  assign occupancy = r_occ;
  assign rd_idx    = r_rd_ptr[IW-1:0];
  assign wr_idx    = r_wr_ptr[IW-1:0];
  assign disp_n    = w_disp_n;
  assign buf_pop_n = w_buf_pop;
  assign in_take_n = w_in_take;
  assign wr_n      = w_wr_n;

endmodule

// File: rtl/jmp_dispatch_buf.sv
// Dual-issue rename->jump-IQ dispatch buffer; storage and slot muxing, control in jmp_dispatch_ctrl.
// Same-cycle bypass of incoming uops is enabled by defining JMP_DISP_BYPASS_EN.
module jmp_dispatch_buf
  import jmp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int UOP_W = JMP_UOP_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid1,
  input  logic [UOP_W-1:0]       in_uop1,
  input  logic                   in_valid2,
  input  logic [UOP_W-1:0]       in_uop2,
  output logic                   in_ready,
  input  logic                   no_free_iq_jmp,
  input  logic                   one_free_iq_jmp,
  output logic                   ins_valid1_jmp,
  output logic [UOP_W-1:0]       uop1_jmp,
  output logic                   ins_valid2_jmp,
  output logic [UOP_W-1:0]       uop2_jmp,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IW = $clog2(DEPTH);

  logic [UOP_W-1:0] r_mem [DEPTH];

  logic [IW-1:0]    w_rd_idx;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx1;
  logic [IW-1:0]    w_wr_idx1;
  logic [1:0]       w_disp_n;
  logic [1:0]       w_buf_pop;
  logic [1:0]       w_in_take;
  logic [1:0]       w_wr_n;
  logic [UOP_W-1:0] w_cin0;
  logic [UOP_W-1:0] w_cin1;
  logic [UOP_W-1:0] w_wr_uop0;

  jmp_dispatch_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid1       (in_valid1),
    .in_valid2       (in_valid2),
    .no_free_iq_jmp  (no_free_iq_jmp),
    .one_free_iq_jmp (one_free_iq_jmp),
    .in_ready        (in_ready),
    .occupancy       (occupancy),
    .rd_idx          (w_rd_idx),
    .wr_idx          (w_wr_idx),
    .disp_n          (w_disp_n),
    .buf_pop_n       (w_buf_pop),
    .in_take_n       (w_in_take),
    .wr_n            (w_wr_n)
  );

  // A lone in_valid2 behaves as slot 1 so the buffer stays dense.
  assign w_cin0    = in_valid1 ? in_uop1 : in_uop2;
  assign w_cin1    = in_uop2;
  assign w_wr_uop0 = (w_in_take == 2'd0) ? w_cin0 : w_cin1;
  assign w_rd_idx1 = w_rd_idx + 1'b1;
  assign w_wr_idx1 = w_wr_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (w_wr_n != 2'd0) r_mem[w_wr_idx]  <= w_wr_uop0;
    if (w_wr_n == 2'd2) r_mem[w_wr_idx1] <= w_cin1;
  end

  // Slot k carries the k-th oldest of {buffer, incoming}; buf_pop_n equals disp_n without bypass.
  always_comb begin
    uop1_jmp = (w_buf_pop != 2'd0) ? r_mem[w_rd_idx] : w_cin0;
    if (w_buf_pop == 2'd2)      uop2_jmp = r_mem[w_rd_idx1];
    else if (w_buf_pop == 2'd1) uop2_jmp = w_cin0;
    else                        uop2_jmp = w_cin1;
  end

  assign ins_valid1_jmp = (w_disp_n != 2'd0);
  assign ins_valid2_jmp = (w_disp_n == 2'd2);

  a_no_drop: assert property (@(posedge clk) disable iff (!reset)
    ((in_valid1 || in_valid2) && !flush) |-> in_ready)
    else $error("rename pushed while in_ready=0");

endmodule
